// File: rtl/game_pkg.sv
// Shared game constants and gomba life-cycle state encoding.
// Used by the gomba stomp controller and the movement blocks.
package game_pkg;

    localparam logic [9:0] SPRITE_SIZE  = 10'd32;
    localparam logic [9:0] SCREEN_X_MAX = 10'd639;
    localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        SQUASH = 2'd1,
        GONE   = 2'd2
    } gomba_life_t;

    // Widen to 11 bits before adding so box edges never wrap.
    function automatic logic [10:0] ext_add(
        input logic [9:0] a,
        input logic [9:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/gomba_stomp_ctrl_if.sv
// Bundle between the game logic and the gomba stomp controller.
// master drives positions/frame clock, slave returns life state and pulses.
interface gomba_stomp_ctrl_if;

    logic       frame_clk;
    logic [9:0] mario_x;
    logic [9:0] mario_y;
    logic       mario_falling;
    logic [9:0] gomba_x;
    logic [9:0] gomba_y;
    logic       gomba_alive;
    logic       gomba_squash;
    logic       gomba_visible;
    logic       mario_bounce;
    logic       mario_hit;
    logic       score_add;
    logic       gomba_respawn;

    modport master (
        output frame_clk, mario_x, mario_y, mario_falling,
        output gomba_x, gomba_y,
        input  gomba_alive, gomba_squash, gomba_visible,
        input  mario_bounce, mario_hit, score_add, gomba_respawn
    );

    modport slave (
        input  frame_clk, mario_x, mario_y, mario_falling,
        input  gomba_x, gomba_y,
        output gomba_alive, gomba_squash, gomba_visible,
        output mario_bounce, mario_hit, score_add, gomba_respawn
    );

endinterface

// File: rtl/frame_tick_det.sv
// Two-flop frame_clk synchroniser with rising-edge detector.
// tick_o is high for one clk_i cycle per frame_clk rising edge.
module frame_tick_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic frame_clk_i,
    output logic tick_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= frame_clk_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick_o = s2_q & ~s3_q;

endmodule

// File: rtl/gomba_stomp_ctrl.sv
// Gomba collision classifier and life-cycle FSM (ALIVE/SQUASH/GONE).
// Define GOMBA_RESPAWN_EN to make GONE time out back to ALIVE.
module gomba_stomp_ctrl
    import game_pkg::*;
#(
    parameter logic [9:0] STOMP_MARGIN  = 10'd8,
    parameter logic [7:0] SQUASH_FRAMES = 8'd30,
    parameter logic [7:0] HIT_COOLDOWN  = 8'd60
`ifdef GOMBA_RESPAWN_EN
    ,
    parameter logic [7:0] RESPAWN_FRAMES = 8'd120
`endif
) (
    input  logic               Clk,
    input  logic               Reset,
    gomba_stomp_ctrl_if.slave  bus
);

    logic tick;

    frame_tick_det u_tick (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .frame_clk_i (bus.frame_clk),
        .tick_o      (tick)
    );

    logic overlap, stomp, side;

    always_comb begin
        overlap = ({1'b0, bus.mario_x} < ext_add(bus.gomba_x, SPRITE_SIZE))
                & ({1'b0, bus.gomba_x} < ext_add(bus.mario_x, SPRITE_SIZE))
                & ({1'b0, bus.mario_y} < ext_add(bus.gomba_y, SPRITE_SIZE))
                & ({1'b0, bus.gomba_y} < ext_add(bus.mario_y, SPRITE_SIZE));
        stomp = overlap & bus.mario_falling
              & (ext_add(bus.mario_y, SPRITE_SIZE)
                 <= ext_add(bus.gomba_y, STOMP_MARGIN));
        side  = overlap & ~stomp;
    end

    gomba_life_t state_q, state_d;
    logic [7:0]  cd_q, cd_d;
    logic [7:0]  sq_q, sq_d;
    logic        bounce_d, hit_d, respawn_d;
    logic        alive_q, squash_q, visible_q;
    logic        bounce_q, hit_q;
`ifdef GOMBA_RESPAWN_EN
    logic [7:0]  rs_q, rs_d;
    logic        respawn_q;
`endif

    always_comb begin
        state_d   = state_q;
        cd_d      = cd_q;
        sq_d      = sq_q;
        bounce_d  = 1'b0;
        hit_d     = 1'b0;
        respawn_d = 1'b0;
`ifdef GOMBA_RESPAWN_EN
        rs_d      = rs_q;
`endif
        if (tick) begin
            unique case (state_q)
                ALIVE: begin
                    if (stomp) begin
                        state_d  = SQUASH;
                        sq_d     = SQUASH_FRAMES - 8'd1;
                        cd_d     = 8'd0;
                        bounce_d = 1'b1;
                    end else if (side && cd_q == 8'd0) begin
                        hit_d = 1'b1;
                        cd_d  = HIT_COOLDOWN;
                    end else if (cd_q != 8'd0) begin
                        cd_d = cd_q - 8'd1;
                    end
                end
                SQUASH: begin
                    if (sq_q == 8'd0) begin
                        state_d = GONE;
`ifdef GOMBA_RESPAWN_EN
                        rs_d    = RESPAWN_FRAMES - 8'd1;
`endif
                    end else begin
                        sq_d = sq_q - 8'd1;
                    end
                end
                GONE: begin
`ifdef GOMBA_RESPAWN_EN
                    if (rs_q == 8'd0) begin
                        state_d   = ALIVE;
                        respawn_d = 1'b1;
                    end else begin
                        rs_d = rs_q - 8'd1;
                    end
`endif
                end
                default: state_d = ALIVE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ALIVE;
            cd_q      <= 8'd0;
            sq_q      <= 8'd0;
            alive_q   <= 1'b1;
            squash_q  <= 1'b0;
            visible_q <= 1'b1;
            bounce_q  <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cd_q      <= cd_d;
            sq_q      <= sq_d;
            alive_q   <= (state_d == ALIVE);
            squash_q  <= (state_d == SQUASH);
            visible_q <= (state_d != GONE);
            bounce_q  <= bounce_d;
            hit_q     <= hit_d;
        end
    end

`ifdef GOMBA_RESPAWN_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rs_q      <= 8'd0;
            respawn_q <= 1'b0;
        end else begin
            rs_q      <= rs_d;
            respawn_q <= respawn_d;
        end
    end

    assign bus.gomba_respawn = respawn_q;
`else
    logic unused_respawn;
    assign unused_respawn    = respawn_d;
    assign bus.gomba_respawn = 1'b0;
`endif

    assign bus.gomba_alive   = alive_q;
    assign bus.gomba_squash  = squash_q;
    assign bus.gomba_visible = visible_q;
    assign bus.mario_bounce  = bounce_q;
    assign bus.score_add     = bounce_q;
    assign bus.mario_hit     = hit_q;

endmodule

// File: tb/tb_gomba_stomp_ctrl.sv
// Directed bench for gomba_stomp_ctrl with an expected-output queue.
// Output vector: {alive, squash, visible, bounce, hit, score, respawn}.
module tb_gomba_stomp_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    gomba_stomp_ctrl_if bus ();

    gomba_stomp_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic [6:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [6:0] O_RST    = 7'b1010000;
    localparam logic [6:0] O_HIT    = 7'b1010100;
    localparam logic [6:0] O_STOMP  = 7'b0111010;
    localparam logic [6:0] O_SQUASH = 7'b0110000;
    localparam logic [6:0] O_GONE   = 7'b0000000;
    localparam logic [6:0] O_RESPN  = 7'b1010001;

    function automatic logic [6:0] outs();
        return {bus.gomba_alive, bus.gomba_squash, bus.gomba_visible,
                bus.mario_bounce, bus.mario_hit, bus.score_add,
                bus.gomba_respawn};
    endfunction

    task automatic push(input string tag, input logic [6:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t       e;
        logic [6:0] o;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty observed=%b required=entry", outs());
        end else begin
            e = sb.pop_front();
            o = outs();
            assert (o === e.v) else begin
                failures++;
                $error("FAIL %s observed=%b required=%b", e.tag, o, e.v);
            end
        end
    endtask

    // One frame: raise frame_clk, check outputs on the consuming edge,
    // then check that pulses last exactly one Clk.
    task automatic frame(input string tag, input logic [6:0] v);
        logic [6:0] o;
        push(tag, v);
        bus.frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_now();
        @(posedge Clk);
        #1;
        o = outs();
        checks++;
        assert ((o & 7'b0001111) === 7'b0000000) else begin
            failures++;
            $error("FAIL %s_pulse_len observed=%b required=%b",
                   tag, o & 7'b0001111, 7'b0000000);
        end
        bus.frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic set_mario(input logic [9:0] x, input logic [9:0] y,
                             input logic f);
        bus.mario_x       = x;
        bus.mario_y       = y;
        bus.mario_falling = f;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        bus.frame_clk = 1'b0;
        bus.gomba_x   = 10'd400;
        bus.gomba_y   = 10'd384;
        set_mario(10'd100, 10'd100, 1'b0);
        do_reset();
        push("reset", O_RST);
        check_now();

        // Inputs that change without a frame edge are ignored.
        set_mario(10'd405, 10'd356, 1'b1);
        repeat (8) @(posedge Clk);
        #1;
        push("no_tick", O_RST);
        check_now();

        // Side hit then cooldown.
        set_mario(10'd380, 10'd384, 1'b0);
        frame("side_hit", O_HIT);
        for (int i = 0; i < 60; i++) frame("cooldown", O_RST);
        frame("side_hit61", O_HIT);

        // Margin+1 during cooldown: side contact, no stomp, no hit.
        set_mario(10'd405, 10'd361, 1'b1);
        frame("margin_p1_cd", O_RST);

        // Exact margin stomp, accepted despite active cooldown.
        set_mario(10'd405, 10'd360, 1'b1);
        frame("stomp_margin", O_STOMP);
        for (int i = 0; i < 29; i++) frame("squash", O_SQUASH);
        frame("gone", O_GONE);

`ifdef GOMBA_RESPAWN_EN
        for (int i = 0; i < 119; i++) frame("gone_wait", O_GONE);
        frame("respawn", O_RESPN);
`else
        for (int i = 0; i < 500; i++) frame("gone_stay", O_GONE);
`endif

        // Plain stomp from reset, then async reset mid-SQUASH.
        do_reset();
        set_mario(10'd405, 10'd356, 1'b1);
        frame("stomp", O_STOMP);
        for (int i = 0; i < 5; i++) frame("squash2", O_SQUASH);
        #3;
        Reset = 1'b1;
        #1;
        push("async_rst", O_RST);
        check_now();
        #2;
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        push("post_rst", O_RST);
        check_now();

        // Margin+1 from a clean cooldown is a side hit.
        set_mario(10'd405, 10'd361, 1'b1);
        frame("margin_p1_hit", O_HIT);

        // No contact: nothing happens.
        set_mario(10'd100, 10'd100, 1'b1);
        frame("no_contact", O_RST);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain observed=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
